cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter.sv | 134 +++++++++++++
 tb/tb_cmp_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter around one shared unsigned magnitude
// comparator. Each transaction walks IDLE -> CMP -> RSP and then returns to IDLE.
//
// Handshake rules:
// - A request transfers on a rising edge where reqN_valid and reqN_ready are
//   both high.
// - reqN_ready is only raised in IDLE, and only for the requester that wins
//   arbitration.
// - A response transfers on a rising edge where rspN_valid and rspN_ready are
//   both high.
// - rspN_valid stays high, with rsp_flags stable, until that transfer happens.
module cmp_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [2:0]        rsp_flags,
  output logic              busy,
  output logic [CNT_W-1:0]  done0_cnt,
  output logic [CNT_W-1:0]  done1_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              gnt_id;    // requester owning the current transaction
  logic              last_id;   // requester served most recently
  logic [DATA_W-1:0] a_q, b_q;
  logic              pick;
  logic              any_req;
  logic              rsp_fire;
  logic [2:0]        cmp_flags;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Arbitration: a tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    any_req  = req0_valid | req1_valid;
    pick     = (req0_valid && req1_valid) ? ~last_id : req1_valid;
    rsp_fire = gnt_id ? rsp1_ready : rsp0_ready;
  end

  // Shared comparator, always fed from the latched operands.
  always_comb begin
    cmp_flags = 3'b100;
    if (a_q > b_q)      cmp_flags = 3'b001;
    else if (a_q < b_q) cmp_flags = 3'b010;
  end

  // Next-state and handshake outputs; rst_n gating keeps ready low while in reset.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && rst_n) begin
          req0_ready = ~pick;
          req1_ready = pick;
          state_nxt  = CMP;
        end
      end
      CMP: state_nxt = RSP;
      RSP: begin
        rsp0_valid = ~gnt_id;
        rsp1_valid = gnt_id;
        if (rsp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand/grant capture, result register, counters and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_id    <= 1'b0;
      last_id   <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      rsp_flags <= 3'b000;
      done0_cnt <= '0;
      done1_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id <= pick;
            a_q    <= pick ? req1_a : req0_a;
            b_q    <= pick ? req1_b : req0_b;
          end
        end
        CMP: rsp_flags <= cmp_flags;
        RSP: begin
          if (rsp_fire) begin
            last_id <= gnt_id;
            if (gnt_id) done1_cnt <= done1_cnt + CNT_ONE;
            else        done0_cnt <= done0_cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model (grant rule, flags by arithmetic compare,
// fixed response timing) through an expected-response queue.
module tb_cmp_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk, rst_n;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [2:0]    rsp_flags;
  logic          busy;
  logic [CW-1:0] done0_cnt, done1_cnt;
  logic [1:0]    state_dbg;

  cmp_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_flags(rsp_flags), .busy(busy),
    .done0_cnt(done0_cnt), .done1_cnt(done1_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model state and scoreboard ----------------
  int            n_chk = 0;
  int            n_fail = 0;
  logic [63:0]   op_q0[$];        // pending {a,b} per requester
  logic [63:0]   op_q1[$];
  logic [35:0]   exp_q[$];        // {id, flags, accept cycle}
  int            free_at = 0;     // first cycle the arbiter is expected idle
  logic          m_last = 1'b1;
  logic [CW-1:0] m_cnt0 = '0;
  logic [CW-1:0] m_cnt1 = '0;
  logic [2:0]    m_flags = 3'b000;
  bit            rsp_mode = 1'b1; // 1: always ready, 0: random
  bit            hold1 = 1'b0;    // force rsp1_ready low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model_flags(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a > b) return 3'b001;
    if (a < b) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: begin v = $urandom(); return {v, v}; end
      1: return {32'($urandom_range(0, 7)), 32'($urandom_range(0, 7))};
      default: return {32'($urandom()), 32'($urandom())};
    endcase
  endfunction

  task automatic flush_model();
    op_q0.delete();
    op_q1.delete();
    exp_q.delete();
    m_cnt0  = '0;
    m_cnt1  = '0;
    m_last  = 1'b1;
    m_flags = 3'b000;
    free_at = 0;
  endtask

  // ---------------- driver: request side ----------------
  initial begin
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic idle_e, g, r0, r1;
        idle_e = (cyc >= free_at);
        g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        r0 = idle_e && req0_valid && !g;
        r1 = idle_e && req1_valid && g;
        check("req_ready", {62'd0, req1_ready, req0_ready}, {62'd0, r1, r0});
        check("busy", {63'd0, busy}, {63'd0, !idle_e});
        if (r0) begin
          exp_q.push_back({1'b0, model_flags(op_q0[0][63:32], op_q0[0][31:0]), cyc});
          void'(op_q0.pop_front());
          free_at = 32'h7fffffff;
        end
        if (r1) begin
          exp_q.push_back({1'b1, model_flags(op_q1[0][63:32], op_q1[0][31:0]), cyc});
          void'(op_q1.pop_front());
          free_at = 32'h7fffffff;
        end
      end
      @(posedge clk);
      #1;
      req0_valid = (op_q0.size() != 0);
      req1_valid = (op_q1.size() != 0);
      if (req0_valid) {req0_a, req0_b} = op_q0[0];
      if (req1_valid) {req1_a, req1_b} = op_q1[0];
      rsp0_ready = rsp_mode ? 1'b1 : 1'($urandom_range(0, 1));
      rsp1_ready = hold1 ? 1'b0 : (rsp_mode ? 1'b1 : 1'($urandom_range(0, 1)));
    end
  end

  // ---------------- monitor: response side ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      logic [1:0] exp_v;
      logic [2:0] exp_f;
      logic       id;
      int         acc;
      check("done_cnt", {56'd0, done1_cnt, done0_cnt}, {56'd0, m_cnt1, m_cnt0});
      exp_v = 2'b00;
      exp_f = m_flags;
      id    = 1'b0;
      if (exp_q.size() > 0) begin
        id  = exp_q[0][35];
        acc = int'(exp_q[0][31:0]);
        if (cyc >= acc + 2) begin
          exp_v = id ? 2'b10 : 2'b01;
          exp_f = exp_q[0][34:32];
        end
      end
      check("rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, {62'd0, exp_v});
      check("rsp_flags", {61'd0, rsp_flags}, {61'd0, exp_f});
      if (exp_v != 2'b00 && (id ? rsp1_ready : rsp0_ready)) begin
        if (id) m_cnt1 = m_cnt1 + 1'b1;
        else    m_cnt0 = m_cnt0 + 1'b1;
        m_last  = id;
        m_flags = exp_f;
        free_at = cyc + 1;
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- sequence helpers ----------------
  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (!(op_q0.size() == 0 && op_q1.size() == 0 && exp_q.size() == 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain", {63'd0, (t < budget)}, 64'd1);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    check("reset_outs",
          {47'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid, busy, rsp_flags, done1_cnt, done0_cnt},
          64'd0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    assert_reset();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs",
          {47'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid, busy, rsp_flags, done1_cnt, done0_cnt},
          64'd0);
    #1;
    rst_n = 1'b1;

    // single request
    op_q0.push_back({32'd5, 32'd3});
    wait_drain(50);
    @(negedge clk);
    check("single_cnt0", {60'd0, done0_cnt}, 64'd1);
    check("single_flags", {61'd0, rsp_flags}, 64'b001);

    // tie after reset, then six alternating grants
    do_reset();
    op_q0.push_back({32'd7, 32'd7});
    op_q1.push_back({32'd2, 32'd9});
    wait_drain(50);
    for (int i = 0; i < 3; i++) begin
      op_q0.push_back(rand_op());
      op_q1.push_back(rand_op());
    end
    wait_drain(100);
    @(negedge clk);
    check("alt_cnt", {56'd0, done1_cnt, done0_cnt}, {56'd0, 4'd4, 4'd4});

    // boundary operands
    op_q0.push_back({32'hFFFFFFFF, 32'h0});
    wait_drain(50);
    op_q0.push_back({32'h0, 32'hFFFFFFFF});
    wait_drain(50);
    @(negedge clk);
    check("boundary_flags", {61'd0, rsp_flags}, 64'b010);

    // response backpressure on requester 1 with requester 0 waiting
    hold1 = 1'b1;
    op_q1.push_back({32'd1, 32'd2});
    repeat (3) @(negedge clk);
    #1;
    op_q0.push_back({32'd4, 32'd4});
    repeat (10) @(negedge clk);
    check("bp_held", {61'd0, rsp1_valid, busy, req0_ready}, 64'b110);
    check("bp_flags", {61'd0, rsp_flags}, 64'b010);
    #1;
    hold1 = 1'b0;
    wait_drain(50);

    // reset while in CMP discards the transaction
    op_q1.push_back({32'd9, 32'd1});
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) break;
    end
    check("cmp_reached", {63'd0, (exp_q.size() > 0)}, 64'd1);
    assert_reset();
    repeat (5) @(negedge clk);
    #1;
    op_q0.push_back({32'd3, 32'd3});
    op_q1.push_back({32'd3, 32'd8});
    wait_drain(50);
    @(negedge clk);
    check("post_reset_cnt", {56'd0, done1_cnt, done0_cnt}, {56'd0, 4'd1, 4'd1});

    // randomized traffic with random response backpressure; counters wrap
    #1;
    rsp_mode = 1'b0;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      #1;
      case ($urandom_range(0, 2))
        0: op_q0.push_back(rand_op());
        1: op_q1.push_back(rand_op());
        default: begin
          op_q0.push_back(rand_op());
          op_q1.push_back(rand_op());
        end
      endcase
    end
    wait_drain(3000);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
